// File: rtl/adpcm_pkg.sv
// Shared widths, sync marker and nibble-phase state for the ADPCM nibble packer.
package adpcm_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic {
        EMPTY_HALF = 1'b0,
        HIGH_HELD  = 1'b1
    } nib_state_e;

    function automatic logic [BYTE_W-1:0] pack_byte(input logic [CODE_W-1:0] hi,
                                                    input logic [CODE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/adpcm_nibble_packer_if.sv
// Code-in / byte-out stream bundle; slave side is the packer, master side the user.
interface adpcm_nibble_packer_if;
    import adpcm_pkg::*;

    logic              in_valid;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic [BYTE_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_code,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  out_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/adpcm_byte_fifo.sv
// First-word-fall-through byte FIFO; simultaneous push and pop succeed even when full.
module adpcm_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Extra pointer bit distinguishes full from empty.
    assign o_level   = r_wptr - r_rptr;
    assign o_full    = (o_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wptr == r_rptr);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/adpcm_nibble_packer.sv
// Packs 4-bit ADPCM codes high-nibble-first into bytes queued in a FWFT FIFO.
// Optional periodic 8'hA5 sync marker when PACKER_SYNC_EN is defined.
module adpcm_nibble_packer
    import adpcm_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_PERIOD = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_clr_ovf,
    adpcm_nibble_packer_if.slave       bus,
    output logic                       o_overflow,
    output logic [$clog2(DEPTH):0]     o_level
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_PERIOD < 1) begin : g_param_check
        $error("adpcm_nibble_packer: illegal DEPTH or SYNC_PERIOD");
    end

    nib_state_e        r_state;
    nib_state_e        w_nxt_state;
    logic [CODE_W-1:0] r_held;
    logic [CODE_W-1:0] w_nxt_held;
    logic              r_en_d;
    logic              r_overflow;
    logic              w_en_fall;
    logic              w_data_push;
    logic [BYTE_W-1:0] w_data_byte;
    logic              w_push;
    logic [BYTE_W-1:0] w_push_byte;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [BYTE_W-1:0] w_rdata;

    assign w_en_fall = r_en_d && !i_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY_HALF;
            r_held  <= '0;
            r_en_d  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_held  <= w_nxt_held;
            r_en_d  <= i_en;
        end
    end

    // Nibble phase: first code of a pair is held as the high nibble.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_held  = r_held;
        w_data_push = 1'b0;
        w_data_byte = '0;
        case (r_state)
            EMPTY_HALF: begin
                if (bus.in_valid && i_en) begin
                    w_nxt_held  = bus.in_code;
                    w_nxt_state = HIGH_HELD;
                end
            end
            HIGH_HELD: begin
                if (bus.in_valid && i_en) begin
                    w_data_push = 1'b1;
                    w_data_byte = pack_byte(r_held, bus.in_code);
                    w_nxt_state = EMPTY_HALF;
                end else if (w_en_fall) begin
                    w_data_push = 1'b1;
                    w_data_byte = pack_byte(r_held, CODE_W'(0));
                    w_nxt_state = EMPTY_HALF;
                end
            end
            default: w_nxt_state = EMPTY_HALF;
        endcase
    end

`ifdef PACKER_SYNC_EN
    localparam int unsigned CNT_W = $clog2(SYNC_PERIOD + 1);

    logic [CNT_W-1:0] r_sync_cnt;
    logic             r_sync_pend;
    logic             w_sync_hit;

    assign w_sync_hit = w_data_push && (r_sync_cnt == CNT_W'(SYNC_PERIOD - 1));

    // Marker goes out the cycle after the period-completing data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_cnt  <= '0;
            r_sync_pend <= 1'b0;
        end else begin
            r_sync_pend <= w_sync_hit;
            if (!i_en)            r_sync_cnt <= '0;
            else if (w_sync_hit)  r_sync_cnt <= '0;
            else if (w_data_push) r_sync_cnt <= r_sync_cnt + CNT_W'(1);
        end
    end

    assign w_push      = w_data_push || r_sync_pend;
    assign w_push_byte = r_sync_pend ? SYNC_BYTE : w_data_byte;
`else
    assign w_push      = w_data_push;
    assign w_push_byte = w_data_byte;
`endif

    assign w_pop = !w_empty && bus.out_ready;

    adpcm_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_byte),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    // Sticky drop flag; a fresh drop beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)                             r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        else if (i_clr_ovf)                  r_overflow <= 1'b0;
    end

    assign o_overflow    = r_overflow;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_rdata;

endmodule

// File: tb/tb_adpcm_nibble_packer.sv
// Directed bench for adpcm_nibble_packer; sync-marker case runs when PACKER_SYNC_EN is defined.
module tb_adpcm_nibble_packer;

`ifdef PACKER_SYNC_EN
    localparam int unsigned TB_DEPTH = 8;
    localparam int unsigned TB_SYNC  = 2;
`else
    localparam int unsigned TB_DEPTH = 4;
    localparam int unsigned TB_SYNC  = 64;
`endif

    logic                      clk;
    logic                      rst;
    logic                      en;
    logic                      clr_ovf;
    logic                      overflow;
    logic [$clog2(TB_DEPTH):0] level;

    int n_tests;
    int n_fail;

    adpcm_nibble_packer_if bus ();

    adpcm_nibble_packer #(
        .DEPTH       (TB_DEPTH),
        .SYNC_PERIOD (TB_SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_clr_ovf  (clr_ovf),
        .bus        (bus),
        .o_overflow (overflow),
        .o_level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] code);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        tick();
        bus.in_valid = 1'b0;
        bus.in_code  = 4'h0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send(b[7:4]);
        send(b[3:0]);
    endtask

    task automatic drain_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        en            = 1'b0;
        clr_ovf       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = 4'h0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        tick();

`ifdef PACKER_SYNC_EN
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        tick();
        check("sync_level", 32'(level), 32'd6);
        drain_check("sync0", 8'h12);
        drain_check("sync1", 8'h34);
        drain_check("sync2", 8'hA5);
        drain_check("sync3", 8'h56);
        drain_check("sync4", 8'h78);
        drain_check("sync5", 8'hA5);
        check("sync_empty", 32'(bus.out_valid), 32'd0);
`else
        // Two codes form one byte, high nibble first.
        bus.out_ready = 1'b1;
        send(4'h3);
        check("pair_half_valid", 32'(bus.out_valid), 32'd0);
        send(4'hC);
        check("pair_valid", 32'(bus.out_valid), 32'd1);
        check("pair_data", 32'(bus.out_data), 32'h3C);
        tick();
        check("pair_popped", 32'(bus.out_valid), 32'd0);
        check("pair_level", 32'(level), 32'd0);

        // Overflow: fifth byte dropped.
        bus.out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("full_ovf_pre", 32'(overflow), 32'd0);
        send_byte(8'h55);
        check("full_level", 32'(level), 32'd4);
        check("full_ovf", 32'(overflow), 32'd1);
        check("full_hold", 32'(bus.out_data), 32'h11);
        tick();
        check("full_hold2", 32'(bus.out_data), 32'h11);
        drain_check("ovf0", 8'h11);
        drain_check("ovf1", 8'h22);
        drain_check("ovf2", 8'h33);
        drain_check("ovf3", 8'h44);
        check("ovf_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pop_empty_level", 32'(level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with push and pop in the same cycle.
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        send(4'hB);
        bus.out_ready = 1'b1;
        send(4'h5);
        bus.out_ready = 1'b0;
        check("pp_level", 32'(level), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        drain_check("pp0", 8'h34);
        drain_check("pp1", 8'h56);
        drain_check("pp2", 8'h78);
        drain_check("pp3", 8'hB5);

        // Falling enable flushes a held nibble only.
        send(4'h7);
        en = 1'b0;
        tick();
        check("flush_level", 32'(level), 32'd1);
        check("flush_data", 32'(bus.out_data), 32'h70);
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check("noflush_level", 32'(level), 32'd1);
        send(4'h9);
        check("en_low_ignored", 32'(level), 32'd1);
        en = 1'b1;
        send_byte(8'h12);
        check("after_en_level", 32'(level), 32'd2);
        drain_check("fl0", 8'h70);
        drain_check("fl1", 8'h12);

        // Reset mid-stream discards queued bytes and the held nibble.
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        send(4'hF);
        check("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_level", 32'(level), 32'd0);
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        tick();
        check("mrst_noflush", 32'(level), 32'd0);
        send(4'h1);
        send(4'h2);
        check("mrst_byte_level", 32'(level), 32'd1);
        check("mrst_byte", 32'(bus.out_data), 32'h12);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
